// File: rtl/avg_window_sequencer.sv
// avg_window_sequencer: collects a row-major stream of pixels into a 16x16
// window, accumulates their sum and presents window/sum/mean until the
// consumer acknowledges.
module avg_window_sequencer #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int PIX_W = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_b,
  input  logic                                  start,
  input  logic [PIX_W-1:0]                      pix_in,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  output logic [ROWS-1:0][COLS-1:0][PIX_W-1:0]  window_data,
  output logic [15:0]                           win_sum,
  output logic [7:0]                            win_avg,
  output logic                                  win_valid,
  input  logic                                  win_ack,
  output logic                                  busy,
  output logic [3:0]                            row_idx,
  output logic [3:0]                            col_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, VALID} state_t;

  state_t state, state_nxt;
  logic   clear;
  logic   accept;
  logic   last_pix;

  assign last_pix = (row_idx == 4'd15) && (col_idx == 4'd15);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the clear/accept strobes for the datapath.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // A restart wins over a pixel presented in the same cycle.
        if (start) begin
          clear = 1'b1;
        end else if (pix_valid) begin
          accept = 1'b1;
          if (last_pix) state_nxt = VALID;
        end
      end
      VALID: begin
        if (win_ack) begin
          if (start) begin
            clear     = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    pix_ready = (state == LOAD);
    win_valid = (state == VALID);
    busy      = (state != IDLE);
    win_avg   = win_sum[15:8];
  end

  // Write pointer and running sum; indices wrap to 0 after the 256th pixel.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      row_idx <= '0;
      col_idx <= '0;
      win_sum <= '0;
    end else if (clear) begin
      row_idx <= '0;
      col_idx <= '0;
      win_sum <= '0;
    end else if (accept) begin
      col_idx <= col_idx + 4'd1;
      if (col_idx == 4'd15) row_idx <= row_idx + 4'd1;
      win_sum <= win_sum + 16'(pix_in);
    end
  end

  // Window storage; not cleared on restart, stale cells are overwritten.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      window_data <= '0;
    end else if (accept) begin
      window_data[row_idx][col_idx] <= pix_in;
    end
  end

endmodule
